// File: rtl/mem_port_arbiter.sv
// Fetch/M-stage arbiter for one single-ported, variable-latency memory.
// Optional perf counters: define MEM_PORT_PERF_EN.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic [31:0] IfRdata,
    output logic        IfValid,
    input  logic        DReq,
    input  logic [5:0]  opcodeM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] DWdata,
    output logic [31:0] DRdata,
    output logic        DValid,
    output logic        StallF,
    output logic        StallM,
    output logic        Misalign,
    output logic        BusError,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWdata,
    input  logic        MemAck,
    input  logic [31:0] MemRdata
`ifdef MEM_PORT_PERF_EN
    ,
    output logic [31:0] PerfStallCnt,
    output logic [31:0] PerfAccessCnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [7:0] TMO_L = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] STV_L = 8'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        gnt_m_q, gnt_m_d;
    logic [7:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;
    logic [31:0] ird_q, ird_d;
    logic [31:0] drd_q, drd_d;

    logic        op_b, op_h, op_w, op_st;
    logic        dlegal, misal, take_m, done;
    logic [3:0]  d_be;
    logic [31:0] d_wd, rd_val;
    logic        unused_ok;

    assign unused_ok = ^IfAddr[1:0];

    always_comb begin
        op_b  = 1'b0;
        op_h  = 1'b0;
        op_w  = 1'b0;
        op_st = 1'b0;
        case (opcodeM)
            6'b100000, 6'b100100: op_b = 1'b1;
            6'b100001, 6'b100101: op_h = 1'b1;
            6'b100011:            op_w = 1'b1;
            6'b101000: begin op_b = 1'b1; op_st = 1'b1; end
            6'b101001: begin op_h = 1'b1; op_st = 1'b1; end
            6'b101011: begin op_w = 1'b1; op_st = 1'b1; end
            default: ;
        endcase
    end

    assign dlegal = DReq & (op_b | op_h | op_w);
    assign misal  = (op_h & ALUoutM[0]) | (op_w & (|ALUoutM[1:0]));

    always_comb begin
        d_be = 4'b1111;
        d_wd = '0;
        unique case (1'b1)
            op_b & op_st: begin
                d_be = 4'b1000 >> ALUoutM[1:0];
                d_wd = {4{DWdata[7:0]}};
            end
            op_h & op_st: begin
                d_be = ALUoutM[1] ? 4'b0011 : 4'b1100;
                d_wd = {2{DWdata[15:0]}};
            end
            op_w & op_st: d_wd = DWdata;
            default: ;
        endcase
    end

    // F wins only once it has watched STARVE_LIMIT M grants in a row
    assign take_m = dlegal & ~(IfReq & (starve_q == STV_L));
    assign done   = MemAck | (tmo_q == TMO_L - 8'd1);
    assign rd_val = (MemAck & ~we_q) ? MemRdata : 32'd0;

    always_comb begin
        state_d  = state_q;
        gnt_m_d  = gnt_m_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wd_d     = wd_q;
        mis_d    = mis_q;
        berr_d   = berr_q;
        ird_d    = ird_q;
        drd_d    = drd_q;
        unique case (state_q)
            S_IDLE: begin
                mis_d  = 1'b0;
                berr_d = 1'b0;
                tmo_d  = '0;
                if (take_m) begin
                    gnt_m_d = 1'b1;
                    if (IfReq && starve_q != STV_L)
                        starve_d = starve_q + 8'd1;
                    if (misal) begin
                        mis_d   = 1'b1;
                        drd_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = op_st;
                        addr_d  = {ALUoutM[31:2], 2'b00};
                        be_d    = d_be;
                        wd_d    = d_wd;
                        state_d = S_BUSY;
                    end
                end else if (IfReq) begin
                    gnt_m_d  = 1'b0;
                    starve_d = '0;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = {IfAddr[31:2], 2'b00};
                    be_d     = 4'b1111;
                    wd_d     = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (done) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    berr_d  = ~MemAck;
                    state_d = S_RESP;
                    if (gnt_m_q) drd_d = rd_val;
                    else         ird_d = rd_val;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            gnt_m_q  <= 1'b0;
            starve_q <= '0;
            tmo_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wd_q     <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
            ird_q    <= '0;
            drd_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_m_q  <= gnt_m_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wd_q     <= wd_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
            ird_q    <= ird_d;
            drd_q    <= drd_d;
        end
    end

    assign IfValid  = (state_q == S_RESP) & ~gnt_m_q;
    assign DValid   = (state_q == S_RESP) & gnt_m_q;
    assign Misalign = (state_q == S_RESP) & mis_q;
    assign BusError = (state_q == S_RESP) & berr_q;
    assign IfRdata  = ird_q;
    assign DRdata   = drd_q;
    assign StallF   = Reset_n & IfReq & ~IfValid;
    assign StallM   = Reset_n & dlegal & ~DValid;
    assign MemReq   = req_q;
    assign MemWe    = we_q;
    assign MemAddr  = addr_q;
    assign MemBe    = be_q;
    assign MemWdata = wd_q;

`ifdef MEM_PORT_PERF_EN
    logic [31:0] pstall_q, pacc_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pstall_q <= '0;
            pacc_q   <= '0;
        end else begin
            if (StallF | StallM)
                pstall_q <= pstall_q + 32'd1;
            if (state_q == S_BUSY && done)
                pacc_q <= pacc_q + 32'd1;
        end
    end

    assign PerfStallCnt  = pstall_q;
    assign PerfAccessCnt = pacc_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT_CYCLES=4).
// Perf counter checks are built when MEM_PORT_PERF_EN is defined.
module tb_mem_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        IfReq = 1'b0;
    logic [31:0] IfAddr = '0;
    logic [31:0] IfRdata;
    logic        IfValid;
    logic        DReq = 1'b0;
    logic [5:0]  opcodeM = '0;
    logic [31:0] ALUoutM = '0;
    logic [31:0] DWdata = '0;
    logic [31:0] DRdata;
    logic        DValid;
    logic        StallF, StallM, Misalign, BusError;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWdata;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRdata;
    logic        ack_en = 1'b0;
    logic [31:0] mem_rd = '0;
`ifdef MEM_PORT_PERF_EN
    logic [31:0] PerfStallCnt, PerfAccessCnt;
`endif

    int checks = 0;
    int errors = 0;

    assign MemAck   = MemReq & ack_en;
    assign MemRdata = mem_rd;

    always #5 Clock = ~Clock;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4), .STARVE_LIMIT(2)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .IfReq(IfReq), .IfAddr(IfAddr),
        .IfRdata(IfRdata), .IfValid(IfValid),
        .DReq(DReq), .opcodeM(opcodeM),
        .ALUoutM(ALUoutM), .DWdata(DWdata),
        .DRdata(DRdata), .DValid(DValid),
        .StallF(StallF), .StallM(StallM),
        .Misalign(Misalign), .BusError(BusError),
        .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemBe(MemBe),
        .MemWdata(MemWdata),
        .MemAck(MemAck), .MemRdata(MemRdata)
`ifdef MEM_PORT_PERF_EN
        ,
        .PerfStallCnt(PerfStallCnt),
        .PerfAccessCnt(PerfAccessCnt)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic xfer(input bit f, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [3:0] be, output logic [31:0] wdat,
                        output logic [31:0] maddr, output logic we,
                        output logic [31:0] rdat, output int lat,
                        output int nreq, output logic mis,
                        output logic berr);
        bit got;
        got = 1'b0;
        be = '0; wdat = '0; maddr = '0; we = 1'b0;
        rdat = '0; lat = 0; nreq = 0; mis = 1'b0; berr = 1'b0;
        tick();
        if (f) begin
            IfReq = 1'b1; IfAddr = a;
        end else begin
            DReq = 1'b1; opcodeM = op; ALUoutM = a; DWdata = wd;
        end
        for (int i = 0; i < 20; i++) begin
            mid();
            if (MemReq) begin
                nreq++;
                be = MemBe; wdat = MemWdata;
                maddr = MemAddr; we = MemWe;
            end
            if (f ? IfValid : DValid) begin
                rdat = f ? IfRdata : DRdata;
                mis  = Misalign;
                berr = BusError;
                got  = 1'b1;
                break;
            end
            lat++;
            tick();
        end
        if (!got) chk("xfer_bound", 0, 1);
        tick();
        IfReq = 1'b0;
        DReq  = 1'b0;
    endtask

    logic [3:0]  be;
    logic [31:0] wdat, maddr, rdat;
    logic        we, mis, berr;
    int          lat, nreq;
    logic [5:0]  order;
    int          nv;
    bit          clash;

    initial begin
        #3;
        chk("rst_memreq", MemReq, 0);
        chk("rst_valids", {IfValid, DValid, Misalign, BusError}, 0);
        chk("rst_addr", MemAddr, 0);
        #10 Reset_n = 1'b1;

        // zero-wait fetch, cycle by cycle
        ack_en = 1'b1;
        mem_rd = 32'hDEADBEEF;
        tick();
        IfReq = 1'b1; IfAddr = 32'h0000_1006;
        mid();
        chk("f_c0_stall", StallF, 1);
        chk("f_c0_req", MemReq, 0);
        tick(); mid();
        chk("f_c1_req", MemReq, 1);
        chk("f_c1_addr", MemAddr, 32'h0000_1004);
        chk("f_c1_be", MemBe, 4'b1111);
        chk("f_c1_we", MemWe, 0);
        chk("f_c1_stall", StallF, 1);
        tick(); mid();
        chk("f_c2_valid", IfValid, 1);
        chk("f_c2_data", IfRdata, 32'hDEADBEEF);
        chk("f_c2_stall", StallF, 0);
        tick();
        IfReq = 1'b0;
        mid();
        chk("f_c3_valid", IfValid, 0);
        chk("f_c3_hold", IfRdata, 32'hDEADBEEF);

        // byte and halfword stores
        xfer(0, 6'b101000, 32'h0000_0302, 32'h1234_56AB,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        chk("sb_be", be, 4'b0010);
        chk("sb_wd", wdat, 32'hABAB_ABAB);
        chk("sb_we", we, 1);
        chk("sb_addr", maddr, 32'h0000_0300);
        chk("sb_lat", lat, 2);
        chk("sb_rd", rdat, 0);
        xfer(0, 6'b101001, 32'h0000_0302, 32'h0000_BEEF,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        chk("sh_be", be, 4'b0011);
        chk("sh_wd", wdat, 32'hBEEF_BEEF);

        // aligned word load
        mem_rd = 32'hCAFE_F00D;
        xfer(0, 6'b100011, 32'h0000_0200, 32'hFFFF_FFFF,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        chk("lw_be_wd_we", {be, wdat[3:0], 3'b0, we}, 12'hF00);
        chk("lw_rd", rdat, 32'hCAFE_F00D);
        chk("lw_lat", lat, 2);

        // misaligned word load
        xfer(0, 6'b100011, 32'h0000_0101, 32'h0,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        chk("mis_nreq", nreq, 0);
        chk("mis_lat", lat, 1);
        chk("mis_flag", mis, 1);
        chk("mis_rd", rdat, 0);

        // non-memory opcode
        tick();
        DReq = 1'b1; opcodeM = 6'b000000;
        mid();
        chk("nop_stall", StallM, 0);
        tick(); mid();
        chk("nop_req", MemReq, 0);
        tick();
        DReq = 1'b0;

        // contention: M,M,F,M,M,F
        order = '0; nv = 0; clash = 1'b0;
        tick();
        IfReq = 1'b1; IfAddr = 32'h0000_0040;
        DReq = 1'b1; opcodeM = 6'b100011; ALUoutM = 32'h80;
        for (int c = 0; c < 40 && nv < 6; c++) begin
            mid();
            if (IfValid && DValid) clash = 1'b1;
            if (IfValid || DValid) begin
                order = {order[4:0], DValid};
                nv++;
            end
            tick();
        end
        IfReq = 1'b0; DReq = 1'b0;
        chk("arb_count", nv, 6);
        chk("arb_order", order, 6'b110110);
        chk("arb_clash", clash, 0);

        // timeout with no ack
        ack_en = 1'b0;
        xfer(0, 6'b100011, 32'h0000_0500, 32'h0,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        chk("tmo_nreq", nreq, 4);
        chk("tmo_lat", lat, 5);
        chk("tmo_berr", berr, 1);
        chk("tmo_rd", rdat, 0);

        // reset during BUSY
        tick();
        DReq = 1'b1; opcodeM = 6'b100011; ALUoutM = 32'h600;
        tick(); mid();
        chk("rb_req", MemReq, 1);
        #1 Reset_n = 1'b0;
        #1;
        chk("rb_async", MemReq, 0);
        DReq = 1'b0;
        tick();
        Reset_n = 1'b1;
        mid();
        chk("rb_idle", {MemReq, IfValid, DValid, StallM}, 0);
        ack_en = 1'b1;
        mem_rd = 32'h0BAD_F00D;
        xfer(1, 6'b0, 32'h0000_0010, 32'h0,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        chk("rb_fetch_lat", lat, 2);
        chk("rb_fetch_rd", rdat, 32'h0BAD_F00D);

`ifdef MEM_PORT_PERF_EN
        Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
        xfer(1, 6'b0, 32'h0000_0020, 32'h0,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        xfer(0, 6'b101011, 32'h0000_0024, 32'h5,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        xfer(0, 6'b100001, 32'h0000_0028, 32'h0,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        xfer(0, 6'b100101, 32'h0000_0029, 32'h0,
             be, wdat, maddr, we, rdat, lat, nreq, mis, berr);
        tick(); mid();
        chk("perf_acc", PerfAccessCnt, 3);
        chk("perf_stall", PerfStallCnt, 7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, word-wide, variable-latency memory between the fetch stage (F) and the memory stage (M) of the 3-stage MIPS pipeline.
- Arbitrates between the two requesters, generates big-endian byte enables and lane-replicated store data, and detects misaligned accesses.
- Drives the pipeline stall signals and handles timeout of stuck memory transactions.
- Returns the raw read word; LoadMasker downstream performs sign/zero extension.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY waiting for MemAck before abort (1..255)
STARVE_LIMIT, 2, consecutive M grants while F waits before F is forced to win

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
IfReq  in  1  fetch request; held until IfValid
IfAddr  in  32  fetch address (bits 1:0 ignored)
IfRdata  out  32  fetched word, valid when IfValid=1
IfValid  out  1  one-cycle completion pulse for fetch
DReq  in  1  M-stage request; held until DValid
opcodeM  in  6  M-stage opcode
ALUoutM  in  32  M-stage byte address
DWdata  in  32  store source (rt), unshifted
DRdata  out  32  raw memory word to LoadMasker ReadDataM
DValid  out  1  one-cycle completion pulse for M
StallF  out  1  IfReq & ~IfValid (combinational)
StallM  out  1  DLegal & ~DValid (combinational)
Misalign  out  1  one-cycle pulse: misaligned M access rejected
BusError  out  1  one-cycle pulse: timeout abort
MemReq  out  1  memory request, registered
MemWe  out  1  write enable, registered
MemAddr  out  32  word address {addr[31:2],2'b00}
MemBe  out  4  byte enables, bit3 = bits 31:24
MemWdata  out  32  lane-replicated store data
MemAck  in  1  memory completes current request this cycle
MemRdata  in  32  read data, valid with MemAck

Behaviour:
- DLegal = DReq & opcodeM ∈ {LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011}.
- DReq with any other opcode is ignored: no stall, no request.
- Reset (async, Reset_n=0):
  - All outputs 0; FSM to IDLE; starvation and timeout counters cleared.
  - Any in-flight transaction is dropped immediately, with MemReq deasserted asynchronously.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE, arbitration:
  - If DLegal, grant M, unless F is waiting and starve count = STARVE_LIMIT, in which case grant F.
  - Else if IfReq, grant F.
  - Granting F clears the starve count. Granting M while IfReq=1 increments it (saturating).
- IDLE, M granted and misaligned:
  - Misaligned means: halfword (LH/LHU/SH) with addr[0]=1, or word (LW/SW) with addr[1:0]≠0.
  - No memory request. Go to RESP with DRdata=0, Misalign=1, DValid=1.
- IDLE, otherwise on grant:
  - Register MemReq=1, MemAddr, MemWe (store=1), MemBe, MemWdata; go to BUSY.
  - Store byte enables: SB BE=4'b1000>>addr[1:0]; SH addr[1]=0 -> 1100, addr[1]=1 -> 0011; SW 1111.
  - Store data: SB {4{rt[7:0]}}; SH {2{rt[15:0]}}; SW rt.
  - Loads: BE=1111, MemWdata=0.
- BUSY:
  - Memory outputs held stable.
  - On MemAck: capture MemRdata (loads and fetches; stores return 0), drop MemReq, go to RESP.
  - Timeout counter increments each BUSY cycle without MemAck. At TIMEOUT_CYCLES: drop MemReq, go to RESP with data 0 and BusError=1.
  - MemAck coincident with the timeout cycle counts as success.
- RESP:
  - Exactly one of IfValid/DValid is 1, with its data. No arbitration this cycle, so a held request is never re-served.
  - Next state is IDLE.
  - IfRdata/DRdata hold their value until the next RESP for that port.
- Latency with zero-wait memory: request visible in cycle 0, MemReq in cycle 1 (MemAck in cycle 1), Valid in cycle 2.
- Throughput: one access per 3 cycles. Each extra wait cycle adds 1.
- MemAck outside BUSY is ignored.

Optional Feature:
- Macro: MEM_PORT_PERF_EN.
- With the macro, adds ports:
  - PerfStallCnt out 32: cycles with StallF|StallM=1.
  - PerfAccessCnt out 32: completed memory transactions; excludes misaligned rejects, includes timeouts.
  - Both counters are cleared by reset and wrap at 2^32.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Zero-wait fetch: IfReq=1, IfAddr=0x0000_1006, MemAck=1 and MemRdata=0xDEADBEEF in MemReq cycles -> MemAddr=0x0000_1004, BE=1111, IfValid pulse in cycle 2 with 0xDEADBEEF; StallF=1 in cycles 0-1.
- SB at addr ...02, rt=0x123456AB -> MemBe=0010, MemWdata=0xABABABAB, MemWe=1, DValid after ack. SH at ...02, rt=0x0000BEEF -> MemBe=0011, MemWdata=0xBEEFBEEF.
- Misaligned LW at 0x0000_0101 -> no MemReq, Misalign and DValid pulse in cycle 1, DRdata=0. Opcode 000000 with DReq=1 -> StallM=0, no activity.
- Contention: IfReq and DReq (LW) held continuously, each served -> order M, M, F, M, M, F. IfValid/DValid never coincide.
- Timeout: TIMEOUT_CYCLES=4, MemAck held 0 -> MemReq drops after 4 BUSY cycles, BusError and DValid pulse. Reset_n low mid-BUSY -> MemReq=0 immediately, FSM IDLE after release.
- With MEM_PORT_PERF_EN: 3 zero-wait accesses plus 1 misaligned -> PerfAccessCnt=3, PerfStallCnt=7.
